// File: rtl/ofs_pkg.sv
// Shared definitions for the operand fetch stage: operand mode codes and FSM state encoding.
package ofs_pkg;

    localparam logic [1:0] MB_RAM   = 2'd0;
    localparam logic [1:0] MB_RSVD  = 2'd1;
    localparam logic [1:0] MB_IO    = 2'd2;
    localparam logic [1:0] MB_CONST = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RAM_WAIT = 2'd1,
        ST_IO_WAIT  = 2'd2,
        ST_DONE     = 2'd3
    } ofs_state_e;

endpackage

// File: rtl/operand_fetch_stage_if.sv
// Bundles the decode-side, RAM, IO and execute-side handshakes of the operand fetch stage.
interface operand_fetch_stage_if #(
    parameter int DATA_W = 32,
    parameter int SRC_W  = 8,
    parameter int ADDR_W = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic [1:0]               in_mblock;
    logic [SRC_W-1:0]         in_source;
    logic [ADDR_W-SRC_W-1:0]  in_page;
    logic                     ram_req;
    logic [ADDR_W-1:0]        ram_address;
    logic                     ram_ack;
    logic [DATA_W-1:0]        ram_value;
    logic                     io_req;
    logic [SRC_W-1:0]         io_address;
    logic                     io_ack;
    logic [DATA_W-1:0]        io_value;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_W-1:0]        out_value;
    logic                     out_error;

    // Surrounding pipeline, memory and devices.
    modport master (
        output in_valid, in_mblock, in_source, in_page,
        output ram_ack, ram_value, io_ack, io_value, out_ready,
        input  in_ready, ram_req, ram_address, io_req, io_address,
        input  out_valid, out_value, out_error
    );

    // The fetch stage itself.
    modport slave (
        input  in_valid, in_mblock, in_source, in_page,
        input  ram_ack, ram_value, io_ack, io_value, out_ready,
        output in_ready, ram_req, ram_address, io_req, io_address,
        output out_valid, out_value, out_error
    );
endinterface

// File: rtl/fetch_timeout_ctr.sv
// Wait-cycle counter shared by the RAM and IO wait states; flags the last allowed cycle.
module fetch_timeout_ctr #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CNT_W = (TIMEOUT > 0) ? (($clog2(TIMEOUT + 1) > 1) ? $clog2(TIMEOUT + 1) : 1) : 1;
    localparam logic [CNT_W-1:0] LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expires in the cycle whose missing ack would bring the count up to TIMEOUT.
    assign expired = (TIMEOUT > 0) && enable && (cnt_q == LAST);

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: one request at a time from RAM, an input device or the constant path, registered result.
module operand_fetch_stage
    import ofs_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SRC_W   = 8,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 255
) (
    input logic               clk,
    input logic               reset_n,
    operand_fetch_stage_if.slave bus
);
    ofs_state_e        state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              ram_req_q, ram_req_d;
    logic              io_req_q, io_req_d;
    logic              out_valid_q, out_valid_d;
    logic              out_error_q, out_error_d;
    logic [DATA_W-1:0] out_value_q, out_value_d;
    logic [ADDR_W-1:0] ram_address_q, ram_address_d;
    logic [SRC_W-1:0]  io_address_q, io_address_d;

    logic wait_ack;
    logic tmo_enable;
    logic tmo_expired;

    assign wait_ack   = ((state_q == ST_RAM_WAIT) && bus.ram_ack) ||
                        ((state_q == ST_IO_WAIT)  && bus.io_ack);
    assign tmo_enable = ((state_q == ST_RAM_WAIT) || (state_q == ST_IO_WAIT)) && !wait_ack;

    // Held clear while idle so every wait state starts counting from zero.
    fetch_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state_q == ST_IDLE),
        .enable  (tmo_enable),
        .expired (tmo_expired)
    );

    always_comb begin
        state_d       = state_q;
        ram_req_d     = ram_req_q;
        io_req_d      = io_req_q;
        out_valid_d   = out_valid_q;
        out_error_d   = out_error_q;
        out_value_d   = out_value_q;
        ram_address_d = ram_address_q;
        io_address_d  = io_address_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    case (bus.in_mblock)
                        MB_RAM: begin
                            state_d       = ST_RAM_WAIT;
                            ram_req_d     = 1'b1;
                            ram_address_d = {bus.in_page, bus.in_source};
                        end
                        MB_IO: begin
                            state_d      = ST_IO_WAIT;
                            io_req_d     = 1'b1;
                            io_address_d = bus.in_source;
                        end
                        MB_CONST: begin
                            state_d     = ST_DONE;
                            out_valid_d = 1'b1;
                            out_value_d = DATA_W'(bus.in_source);
                            out_error_d = 1'b0;
                        end
                        default: begin
                            state_d     = ST_DONE;
                            out_valid_d = 1'b1;
                            out_value_d = '0;
                            out_error_d = 1'b1;
                        end
                    endcase
                end
            end
            ST_RAM_WAIT: begin
                if (bus.ram_ack) begin
                    state_d     = ST_DONE;
                    ram_req_d   = 1'b0;
                    out_valid_d = 1'b1;
                    out_value_d = bus.ram_value;
                    out_error_d = 1'b0;
                end else if (tmo_expired) begin
                    state_d     = ST_DONE;
                    ram_req_d   = 1'b0;
                    out_valid_d = 1'b1;
                    out_value_d = '0;
                    out_error_d = 1'b1;
                end
            end
            ST_IO_WAIT: begin
                if (bus.io_ack) begin
                    state_d     = ST_DONE;
                    io_req_d    = 1'b0;
                    out_valid_d = 1'b1;
                    out_value_d = bus.io_value;
                    out_error_d = 1'b0;
                end else if (tmo_expired) begin
                    state_d     = ST_DONE;
                    io_req_d    = 1'b0;
                    out_valid_d = 1'b1;
                    out_value_d = '0;
                    out_error_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        in_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            in_ready_q    <= 1'b1;
            ram_req_q     <= 1'b0;
            io_req_q      <= 1'b0;
            out_valid_q   <= 1'b0;
            out_error_q   <= 1'b0;
            out_value_q   <= '0;
            ram_address_q <= '0;
            io_address_q  <= '0;
        end else begin
            state_q       <= state_d;
            in_ready_q    <= in_ready_d;
            ram_req_q     <= ram_req_d;
            io_req_q      <= io_req_d;
            out_valid_q   <= out_valid_d;
            out_error_q   <= out_error_d;
            out_value_q   <= out_value_d;
            ram_address_q <= ram_address_d;
            io_address_q  <= io_address_d;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.ram_req     = ram_req_q;
    assign bus.ram_address = ram_address_q;
    assign bus.io_req      = io_req_q;
    assign bus.io_address  = io_address_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_value   = out_value_q;
    assign bus.out_error   = out_error_q;

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Sequential successor to the combinational stage-1 operand selector.
- Accepts a decoded operand request (mode + source byte + page), fetches from RAM, an input device, or the constant path, and returns one registered value per request.
- Uses valid/ready upstream and downstream, req/ack with variable latency toward RAM and IO, and a per-access timeout.
- Sits between decode and execute in the processor pipeline.

Parameters:
- DATA_W, 32, operand/data width in bits.
- SRC_W, 8, source field width; equals IO address width and RAM low-address width.
- ADDR_W, 16, RAM address width; must be >= SRC_W.
- TIMEOUT, 255, maximum wait cycles for ack; 0 disables the timeout.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  synchronous, active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  stage can accept a request.
- in_mblock  input  2  mode: 0=RAM, 1=reserved, 2=IO, 3=constant.
- in_source  input  SRC_W  RAM low address / IO address / constant.
- in_page  input  ADDR_W-SRC_W  RAM upper address bits.
- ram_req  output  1  RAM read request.
- ram_address  output  ADDR_W  {page, source}.
- ram_ack  input  1  RAM data valid.
- ram_value  input  DATA_W  RAM read data.
- io_req  output  1  input-device read request.
- io_address  output  SRC_W  device address.
- io_ack  input  1  device data valid.
- io_value  input  DATA_W  device read data.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_value  output  DATA_W  fetched operand.
- out_error  output  1  reserved mode or timeout.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - State goes to IDLE.
  - in_ready=1 after reset; ram_req=0, io_req=0, out_valid=0, out_value=0, out_error=0.
  - ram_address=0, io_address=0, timeout counter=0.
- FSM states: IDLE, RAM_WAIT, IO_WAIT, DONE.
- IDLE:
  - in_ready=1.
  - Acceptance is in_valid&in_ready; it latches mode, source and page.
  - Next state by mode:
    - 0 -> RAM_WAIT.
    - 2 -> IO_WAIT.
    - 3 -> DONE, with out_value = zero-extended in_source and out_error=0.
    - 1 -> DONE, with out_value=0 and out_error=1.
- RAM_WAIT:
  - ram_req=1 and ram_address={page,source}, both held stable until ack or timeout.
  - On ram_ack=1: capture ram_value into out_value, set out_error=0, go to DONE. ram_req falls the next cycle.
- IO_WAIT: same as RAM_WAIT, using io_req, io_address=source, io_ack and io_value.
- Timeout:
  - The counter clears on entry to a WAIT state and increments each cycle without ack.
  - If TIMEOUT>0 and the counter reaches TIMEOUT with no ack: out_value=0, out_error=1, go to DONE, drop req.
  - Ack in the same cycle the counter reaches TIMEOUT wins; this is a normal completion.
  - Counter width is $clog2(TIMEOUT+1), minimum 1.
- DONE:
  - out_valid=1; out_value and out_error are held stable.
  - in_ready=0, so there is no same-cycle refill.
  - On out_ready=1: go to IDLE; out_valid falls the next cycle.
- Latency, from the acceptance edge to out_valid high:
  - Constant or reserved mode: 1 cycle.
  - RAM/IO: 1 cycle for req to rise, plus ack latency, plus 1 cycle.
  - With ack present in the first req cycle, out_valid is 2 cycles after acceptance.
- Throughput: at most one request in flight; in_ready is low in the WAIT and DONE states.
- Stray acks:
  - ram_ack/io_ack are ignored outside their own WAIT state, including late acks after a timeout.
  - The other channel's ack is always ignored.
- Reset mid-operation: synchronous reset overrides any state. req drops at that edge and no result is produced.
- out_value is registered; there is no combinational path from ram_value/io_value to out_value.

Decomposition:
- Shared package `ofs_pkg`:
  - Mode constants: MB_RAM=2'd0, MB_RSVD=2'd1, MB_IO=2'd2, MB_CONST=2'd3.
  - FSM state encoding.
- Sub-module `fetch_timeout_ctr` (parameter TIMEOUT): inputs clear/enable, output `expired`. It is instantiated once and shared, because RAM_WAIT and IO_WAIT are mutually exclusive.

Test Plan:
- Constant mode:
  - Stimulus: in_mblock=3, in_source=8'hA5, out_ready=1.
  - Response: out_valid one cycle after acceptance, with out_value=32'h000000A5 and out_error=0; no req asserted.
- RAM read:
  - Stimulus: in_mblock=0, in_page=8'h12, in_source=8'h34; ram_ack 3 cycles after ram_req with ram_value=32'hDEADBEEF.
  - Response: ram_address=16'h1234 held stable while ram_req is high; out_value=32'hDEADBEEF with out_error=0.
- IO read with backpressure:
  - Stimulus: in_mblock=2, in_source=8'h07; io_ack immediately with io_value=32'h0000_1234; out_ready low for 4 cycles.
  - Response: out_valid and out_value stay stable for those 4 cycles, in_ready=0 throughout, and the stage returns to IDLE after out_ready.
- Timeout:
  - Stimulus: TIMEOUT=4, RAM mode, no ram_ack.
  - Response: ram_req high for exactly 4 cycles, then out_valid with out_error=1 and out_value=0.
  - A late ram_ack afterwards has no effect.
- Reserved mode:
  - Stimulus: in_mblock=1.
  - Response: out_error=1 and out_value=0 after 1 cycle; no req asserted.
- Reset mid-operation:
  - Stimulus: reset_n=0 during IO_WAIT, with io_ack arriving the cycle after reset is released.
  - Response: io_req=0, out_valid=0, in_ready=1; the ack is ignored.
